// File: rtl/ram_burst_reader.sv
// Burst read engine for a simple dual-port RAM with one-cycle registered read data.
// Reads `length` consecutive words from `base_addr` and streams them out in order through a 3-entry buffer.
module ram_burst_reader #(
    parameter int data_width    = 8,
    parameter int address_width = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [address_width-1:0] base_addr,
    input  logic [address_width:0]   length,
    output logic [address_width-1:0] add_r,
    input  logic [data_width-1:0]    data_r,
    output logic [data_width-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

    localparam logic [address_width:0] LEN_ONE = {{address_width{1'b0}}, 1'b1};

    state_e                   state_q, state_d;
    logic [address_width-1:0] add_q, add_d;
    logic [address_width:0]   rem_issue_q, rem_issue_d;
    logic [address_width:0]   rem_out_q, rem_out_d;
    logic                     inflight_q, inflight_d;
    logic                     done_q, done_d;
    logic [1:0]               count_q, count_d;
    logic [1:0]               rd_ptr_q, rd_ptr_d;
    logic [1:0]               wr_ptr_q, wr_ptr_d;
    logic [data_width-1:0]    buf_q [3];

    logic       issue, push, pop;
    logic [2:0] occupancy;

    // Occupancy counts a read still in flight so a stalled sink can never overflow the buffer.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    assign issue     = (state_q == READ) && (rem_issue_q != '0) && (occupancy <= 3'd2);
    assign push      = inflight_q;
    assign pop       = m_valid && m_ready;

    assign add_r   = add_q;
    assign m_valid = (count_q != 2'd0);
    assign m_data  = buf_q[rd_ptr_q];
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

    always_comb begin
        state_d     = state_q;
        add_d       = add_q;
        rem_issue_d = rem_issue_q;
        rem_out_d   = rem_out_q;
        inflight_d  = issue;
        done_d      = 1'b0;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;

        if (push) wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
        if (pop)  rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d     = READ;
                        add_d       = base_addr;
                        rem_issue_d = length;
                        rem_out_d   = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    add_d       = add_q + 1'b1;
                    rem_issue_d = rem_issue_q - 1'b1;
                    if (rem_issue_q == LEN_ONE) state_d = DRAIN;
                end
            end
            DRAIN: ;
            default: state_d = IDLE;
        endcase

        // The final beat can only leave after its read was issued, so this never fires in IDLE.
        if (pop && state_q != IDLE) begin
            rem_out_d = rem_out_q - 1'b1;
            if (rem_out_q == LEN_ONE) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            add_q       <= '0;
            rem_issue_q <= '0;
            rem_out_q   <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 2'd0;
            wr_ptr_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            add_q       <= add_d;
            rem_issue_q <= rem_issue_d;
            rem_out_q   <= rem_out_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
        end else if (push) begin
            buf_q[wr_ptr_q] <= data_r;
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: table of bursts with hand-computed latency, data and done timing,
// plus a mid-burst reset sequence.
module tb_ram_burst_reader;

    localparam int DW = 8;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic [AW-1:0] add_r;
    logic [DW-1:0] data_r;
    logic [DW-1:0] m_data;
    logic          m_valid, busy, done;
    logic [DW-1:0] mem [2**AW];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        int            mode;     // 0: ready high, 1: 1,0,0 then alternating, 2: low until cycle 8
        bit            inj;      // second start while busy at cycle 2
        int            first_k;
        logic [DW-1:0] first_d;
        logic [DW-1:0] last_d;
        int            done_k;
    } vec_t;

    vec_t vecs [8];

    ram_burst_reader #(.data_width(DW), .address_width(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .add_r(add_r), .data_r(data_r), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) data_r <= mem[add_r];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int k);
        case (mode)
            1:       return (k == 1) || (k >= 4 && k % 2 == 0);
            2:       return k >= 8;
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int            beats, dones, first_k, done_k;
        logic          pv, pr;
        logic [DW-1:0] pd, last, exp_d;
        logic [AW-1:0] a;
        beats = 0; dones = 0; first_k = -1; done_k = -1;
        pv = 1'b0; pr = 1'b1; pd = '0; last = '0;
        @(negedge clk);
        start = 1'b1; base_addr = v.base; length = v.len; m_ready = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            start = (v.inj && k == 2);
            if (start) begin base_addr = 7'd60; length = 8'd3; end
            m_ready = rdy(v.mode, k);
            if (k == 1) chk({tag, " busy_start"}, busy, (v.len != 0));
            if (pv && !pr) begin
                chk({tag, " stall_valid"}, m_valid, 1);
                chk({tag, " stall_data"}, m_data, pd);
            end
            if (m_valid && first_k < 0) begin
                first_k = k;
                chk({tag, " first_data"}, m_data, v.first_d);
            end
            if (v.mode == 0 && k <= int'(v.len)) begin
                a = v.base + AW'(k - 1);
                chk({tag, " add_r"}, add_r, a);
            end
            if (m_valid && m_ready) begin
                a     = v.base + AW'(beats);
                exp_d = DW'(a) + 8'h10;
                chk({tag, " beat_data"}, m_data, exp_d);
                last = m_data;
                beats++;
            end
            if (done) begin
                dones++;
                if (done_k < 0) done_k = k;
            end
            if (done_k > 0 && k >= done_k + 2) break;
            pv = m_valid; pr = m_ready; pd = m_data;
        end
        chk({tag, " done_seen"}, (done_k > 0), 1);
        chk({tag, " first_valid_k"}, first_k, v.first_k);
        chk({tag, " beats"}, beats, v.len);
        chk({tag, " done_count"}, dones, 1);
        chk({tag, " done_k"}, done_k, v.done_k);
        if (v.len != 0) chk({tag, " last_data"}, last, v.last_d);
        chk({tag, " busy_end"}, busy, 0);
        chk({tag, " valid_end"}, m_valid, 0);
    endtask

    initial begin
        vec_t vr;
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i + 16);
        //          base    len     mode inj first_k first  last   done_k
        vecs[0] = '{7'd5,   8'd4,   0, 0, 3,  8'h15, 8'h18, 7};
        vecs[1] = '{7'd126, 8'd4,   0, 0, 3,  8'h8E, 8'h11, 7};
        vecs[2] = '{7'd20,  8'd8,   1, 0, 3,  8'h24, 8'h2B, 19};
        vecs[3] = '{7'd40,  8'd5,   2, 0, 3,  8'h38, 8'h3C, 13};
        vecs[4] = '{7'd9,   8'd0,   0, 0, -1, 8'h00, 8'h00, 1};
        vecs[5] = '{7'd5,   8'd4,   0, 1, 3,  8'h15, 8'h18, 7};
        vecs[6] = '{7'd127, 8'd1,   0, 0, 3,  8'h8F, 8'h8F, 4};
        vecs[7] = '{7'd0,   8'd129, 0, 0, 3,  8'h10, 8'h10, 132};

        #2;
        chk("reset add_r", add_r, 0);
        chk("reset m_valid", m_valid, 0);
        chk("reset m_data", m_data, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset while the third beat of a six-word burst is on the stream.
        @(negedge clk);
        start = 1'b1; base_addr = 7'd0; length = 8'd6; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst valid", m_valid, 1);
        chk("pre_rst data", m_data, 8'h12);
        rst_n = 1'b0;
        #1;
        chk("mid_rst m_valid", m_valid, 0);
        chk("mid_rst busy", busy, 0);
        chk("mid_rst done", done, 0);
        chk("mid_rst add_r", add_r, 0);
        chk("mid_rst m_data", m_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        vr = '{7'd0, 8'd2, 0, 0, 3, 8'h10, 8'h11, 5};
        run_vec(vr, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side engine for simple_dual_port_RAM. It drives the RAM's read address and consumes its registered read data, which arrives one cycle after the address.
- On a start command, it reads `length` consecutive words beginning at `base_addr`. The words are delivered in order on a valid/ready stream.
- A 3-entry output buffer absorbs the RAM read latency. This allows full throughput with no combinational path from m_ready to add_r.

Parameters:
data_width, 8, RAM word width in bits
address_width, 7, RAM address width; RAM depth = 2**address_width

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle command strobe; sampled only in IDLE
base_addr  input  address_width  first word address, captured on accepted start
length  input  address_width+1  number of words to read, captured on accepted start; 0 allowed
add_r  output  address_width  RAM read address, registered
data_r  input  data_width  RAM read data; valid the cycle after add_r presented
m_data  output  data_width  stream data (buffer head)
m_valid  output  1  stream data valid
m_ready  input  1  downstream accept
busy  output  1  high from accepted start until burst complete
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (async, rst_n low): state IDLE; add_r=0, m_data=0, m_valid=0, busy=0, done=0. Buffer count, inflight flag and word counters are cleared.
- States:
  - IDLE: start=1 with length!=0 → READ. Captures add_r<=base_addr, remaining_issue<=length, remaining_out<=length, busy<=1.
  - IDLE: start=1 with length==0 → stays IDLE. done pulses the next cycle; busy is never asserted.
  - READ: issues reads. After the last read is issued → DRAIN.
  - DRAIN: waits for the buffer to empty. The handshake of the final beat → IDLE, busy<=0, done<=1 in the following cycle.
- start while busy=1 is ignored (no queuing).
- Issue rule: in READ, a read is issued in a cycle when remaining_issue>0 and (count + inflight) <= 2.
  - count is the number of buffer entries.
  - inflight=1 if a read was issued last cycle.
  - m_ready is not used in this rule.
- When a read issues, the current add_r is the read address. add_r then increments modulo 2**address_width and remaining_issue decrements.
- When no read issues, add_r holds. The stale read data is discarded because inflight=0.
- Return path: if inflight=1, data_r is pushed into the buffer at that edge.
  - The issue rule guarantees the buffer never overflows.
  - Push and pop may occur in the same cycle.
- Stream: m_valid = (count>0); m_data = buffer head.
  - A beat transfers on m_valid&&m_ready; remaining_out then decrements.
  - m_data and m_valid must stay stable while m_valid=1 and m_ready=0.
- Latency: first m_valid rises 2 cycles after the accepted start edge (start edge → add_r=base; +1 issue; +1 data pushed).
- Throughput: with m_ready held high, one beat per cycle, with no bubbles after the first.
- Wrap-around: addresses wrap from 2**address_width-1 to 0. Lengths above the RAM depth re-read wrapped words.
- Write collisions: no interlock with the RAM write port. The returned data is whatever the RAM presents; for a same-address same-cycle write this is the old data.
- Reset mid-burst: the burst is aborted immediately. All outputs return to their reset values and buffered data is lost.

Test Plan:
- RAM preloaded with mem[i]=i+0x10; start with base=5, length=4, m_ready=1 → m_data 0x15,0x16,0x17,0x18 on consecutive cycles; first m_valid 2 cycles after start; done pulses once; busy low afterwards.
- base=126, length=4 (address_width=7) → add_r sequence 126,127,0,1; data 0x8E,0x8F,0x10,0x11.
- length=8; m_ready toggles 1,0,0,1,0,1... → all 8 words in order, none dropped or duplicated; count never exceeds 3; m_data stable while stalled.
- length=0 → busy stays 0, m_valid stays 0, done pulses exactly once, one cycle after start.
- start re-asserted mid-burst with a different base → ignored; the original burst completes unchanged.
- rst_n pulsed low during the 3rd beat of a length=6 burst → m_valid, busy, done, add_r immediately 0. A new start with base=0, length=2 then returns 0x10,0x11 correctly.
